// File: rtl/softmax_sum_sched.sv
// softmax_sum_sched
//   Row-sum scheduler for the softmax-approximation datapath. It streams
//   1..MAX_BEATS beats of 64 FX16 lanes into the external adder tree. It
//   accumulates the per-beat tree sums into up to four saturating row totals,
//   selected by segmentation mode. It hands the totals to the normalisation
//   stage over a valid/ready port.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, cfg_mode, cfg_beats row launch and configuration (sampled in IDLE)
//   busy                      high whenever a row is in progress
//   in_valid/in_ready/in_data input beat stream (64 x 16b signed lanes)
//   tree_*                    adder tree control, data and returned sums
//   out_valid/out_ready       row result handshake
//   out_mode, out_sum_0..3    mode and totals of the completed row
//   out_sat                   per-segment saturation flags for the row
module softmax_sum_sched #(
  parameter int TREE_LAT  = 6,
  parameter int MAX_BEATS = 16,
  parameter int BEAT_W    = 5,
  parameter int ACC_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [BEAT_W-1:0] cfg_beats,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1023:0]     in_data,
  output logic              tree_en,
  output logic              tree_valid,
  output logic [1:0]        tree_length_mode,
  output logic [1023:0]     tree_in_0_flat,
  output logic [1023:0]     tree_in_1_flat,
  input  logic [15:0]       tree_sum_64_0,
  input  logic [15:0]       tree_sum_32_0,
  input  logic [15:0]       tree_sum_32_1,
  input  logic [15:0]       tree_sum_16_0,
  input  logic [15:0]       tree_sum_16_1,
  input  logic [15:0]       tree_sum_16_2,
  input  logic [15:0]       tree_sum_16_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_mode,
  output logic [ACC_W-1:0]  out_sum_0,
  output logic [ACC_W-1:0]  out_sum_1,
  output logic [ACC_W-1:0]  out_sum_2,
  output logic [ACC_W-1:0]  out_sum_3,
  output logic [3:0]        out_sat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Symmetric clamp range: the most negative code is never produced.
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  // Saturating add; returns {saturated, result}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [15:0] op);
    logic signed [ACC_W:0] sum;
    sum = $signed({acc[ACC_W-1], acc}) + $signed({{(ACC_W-15){op[15]}}, op});
    if (sum > ACC_MAX) begin
      sat_add = {1'b1, ACC_MAX[ACC_W-1:0]};
    end else if (sum < ACC_MIN) begin
      sat_add = {1'b1, ACC_MIN[ACC_W-1:0]};
    end else begin
      sat_add = {1'b0, sum[ACC_W-1:0]};
    end
  endfunction

  // Zero beats means one; oversize requests are limited to MAX_BEATS.
  function automatic logic [BEAT_W-1:0] clamp_beats(input logic [BEAT_W-1:0] b);
    if (b == {BEAT_W{1'b0}}) begin
      clamp_beats = BEAT_W'(1);
    end else if (b > BEAT_W'(MAX_BEATS)) begin
      clamp_beats = BEAT_W'(MAX_BEATS);
    end else begin
      clamp_beats = b;
    end
  endfunction

  state_t              state_r, state_next_s;
  logic [1:0]          mode_r;
  logic [BEAT_W-1:0]   beats_r, issued_cnt_r;
  logic [TREE_LAT-1:0] tag_r;
  logic [ACC_W-1:0]    acc_r [4];
  logic [3:0]          sat_r;
  logic                busy_r, in_ready_r, out_valid_r, tree_en_r;
  logic                hs_s, last_hs_s, tag_tail_s;
  logic [3:0]          seg_en_s;
  logic [15:0]         seg_op_s [4];
  logic [ACC_W:0]      add_res_s [4];

  assign hs_s       = in_valid & in_ready_r;
  assign last_hs_s  = hs_s && ((issued_cnt_r + BEAT_W'(1)) == beats_r);
  assign tag_tail_s = tag_r[TREE_LAT-1];

  assign busy             = busy_r;
  assign in_ready         = in_ready_r;
  assign out_valid        = out_valid_r;
  assign tree_en          = tree_en_r;
  assign tree_valid       = hs_s;
  assign tree_length_mode = mode_r;
  assign tree_in_0_flat   = in_data;
  assign tree_in_1_flat   = in_data;
  assign out_mode         = mode_r;
  assign out_sum_0        = acc_r[0];
  assign out_sum_1        = acc_r[1];
  assign out_sum_2        = acc_r[2];
  assign out_sum_3        = acc_r[3];
  assign out_sat          = sat_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. DRAIN ends when only the tail tag (the last beat,
  // accumulating this cycle) or nothing remains in the tag pipe.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_next_s = S_RUN;
        else       state_next_s = S_IDLE;
      end
      S_RUN: begin
        if (last_hs_s) state_next_s = S_DRAIN;
        else           state_next_s = S_RUN;
      end
      S_DRAIN: begin
        if (tag_r[TREE_LAT-2:0] == {(TREE_LAT-1){1'b0}}) state_next_s = S_OUT;
        else                                            state_next_s = S_DRAIN;
      end
      S_OUT: begin
        if (out_ready) state_next_s = S_IDLE;
        else           state_next_s = S_OUT;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Registered status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      tree_en_r   <= 1'b0;
    end else begin
      busy_r      <= (state_next_s != S_IDLE);
      in_ready_r  <= (state_next_s == S_RUN);
      out_valid_r <= (state_next_s == S_OUT);
      tree_en_r   <= 1'b1;
    end
  end

  // Tag pipe mirrors the tree latency; a 1 at the tail marks row-owned sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_r <= {TREE_LAT{1'b0}};
    end else begin
      tag_r <= {tag_r[TREE_LAT-2:0], hs_s};
    end
  end

  // Segment operand selection by latched mode (reserved mode already mapped to 0).
  always_comb begin
    seg_en_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      seg_op_s[k] = 16'd0;
    end
    case (mode_r)
      2'd1: begin
        seg_en_s    = 4'b0011;
        seg_op_s[0] = tree_sum_32_0;
        seg_op_s[1] = tree_sum_32_1;
      end
      2'd2: begin
        seg_en_s    = 4'b1111;
        seg_op_s[0] = tree_sum_16_0;
        seg_op_s[1] = tree_sum_16_1;
        seg_op_s[2] = tree_sum_16_2;
        seg_op_s[3] = tree_sum_16_3;
      end
      default: begin
        seg_en_s    = 4'b0001;
        seg_op_s[0] = tree_sum_64_0;
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      add_res_s[k] = sat_add(acc_r[k], seg_op_s[k]);
    end
  end

  // Row configuration, beat counter, accumulators and sticky saturation flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r       <= 2'd0;
      beats_r      <= {BEAT_W{1'b0}};
      issued_cnt_r <= {BEAT_W{1'b0}};
      sat_r        <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end else if ((state_r == S_IDLE) && start) begin
      mode_r       <= (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
      beats_r      <= clamp_beats(cfg_beats);
      issued_cnt_r <= {BEAT_W{1'b0}};
      sat_r        <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end else begin
      if (hs_s) begin
        issued_cnt_r <= issued_cnt_r + BEAT_W'(1);
      end
      for (int k = 0; k < 4; k++) begin
        if (tag_tail_s && seg_en_s[k]) begin
          acc_r[k] <= add_res_s[k][ACC_W-1:0];
          sat_r[k] <= sat_r[k] | add_res_s[k][ACC_W];
        end
      end
    end
  end

endmodule
